// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the stream demultiplexer family.
package stream_demux_pkg;

  localparam int DROP_CNT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Keeps the select at least one bit wide even for degenerate channel counts.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_demux_sel_decoder.sv
// Select-index to one-hot decoder; flags indices with no matching channel.
module sel_decoder #(
  parameter int NUM_CH = 8,
  parameter int SEL_W  = 3
) (
  input  logic [SEL_W-1:0]  i_sel,
  output logic [NUM_CH-1:0] o_onehot,
  output logic              o_out_of_range
);

  always_comb begin
    o_onehot       = '0;
    o_out_of_range = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (i_sel == SEL_W'(i)) begin
        o_onehot[i]    = 1'b1;
        o_out_of_range = 1'b0;
      end
    end
  end

endmodule

// File: rtl/stream_demux_1xn.sv
// Registered 1-to-N stream demux with unicast/broadcast routing and a
// single-entry holding stage that releases once every target has accepted.
//
//   state | meaning
//   IDLE  | holding stage empty, no m_valid asserted
//   HOLD  | word held, m_valid asserted on channels still in pending mask
module stream_demux_1xn
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 8,
  parameter int SEL_W  = sel_width(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_data,
  input  logic [SEL_W-1:0]      s_sel,
  input  logic                  s_bcast,
  output logic [NUM_CH-1:0]     m_valid,
  input  logic [NUM_CH-1:0]     m_ready,
  output logic [DATA_W-1:0]     m_data,
  output logic                  err_sel,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam logic [DROP_CNT_W-1:0] CNT_MAX = '1;

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [DATA_W-1:0]       r_hold_data;
  logic [NUM_CH-1:0]       r_pending;
  logic                    r_err_sel;
  logic [DROP_CNT_W-1:0]   r_drop_cnt;

  logic [NUM_CH-1:0]       w_onehot;
  logic                    w_oor;
  logic [NUM_CH-1:0]       w_mask;
  logic [NUM_CH-1:0]       w_next_pending;
  logic                    w_accept;
  logic                    w_load;
  logic                    w_drop;

  sel_decoder #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W)
  ) u_sel_decoder (
    .i_sel          (s_sel),
    .o_onehot       (w_onehot),
    .o_out_of_range (w_oor)
  );

  // Drain and new accept may coincide: s_ready looks at what remains after
  // this cycle's handshakes, so back-to-back words never see a bubble.
  assign w_next_pending = r_pending & ~(m_valid & m_ready);
  assign s_ready        = (r_state == IDLE) || (w_next_pending == '0);
  assign w_accept       = s_valid & s_ready;
  assign w_mask         = s_bcast ? {NUM_CH{1'b1}} : (w_oor ? '0 : w_onehot);
  assign w_load         = w_accept & (|w_mask);
  assign w_drop         = w_accept & ~(|w_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = IDLE;
    if (w_load || (w_next_pending != '0)) begin
      w_state_nxt = HOLD;
    end
  end

  always_comb begin
    m_valid  = (r_state == HOLD) ? r_pending : '0;
    m_data   = r_hold_data;
    err_sel  = r_err_sel;
    drop_cnt = r_drop_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_data <= '0;
      r_pending   <= '0;
      r_err_sel   <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      r_err_sel <= w_drop;
      if (w_load) begin
        r_hold_data <= s_data;
        r_pending   <= w_mask;
      end else begin
        r_pending <= w_next_pending;
      end
      if (w_drop && (r_drop_cnt != CNT_MAX)) begin
        r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Directed bench for stream_demux_1xn: an 8-channel instance for routing and
// backpressure, a 6-channel instance for out-of-range drops and saturation.
module tb_stream_demux_1xn;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        s_valid8 = 1'b0;
  logic        s_ready8;
  logic [7:0]  s_data8 = '0;
  logic [2:0]  s_sel8 = '0;
  logic        s_bcast8 = 1'b0;
  logic [7:0]  m_valid8;
  logic [7:0]  m_ready8 = '0;
  logic [7:0]  m_data8;
  logic        err_sel8;
  logic [15:0] drop_cnt8;

  logic        s_valid6 = 1'b0;
  logic        s_ready6;
  logic [7:0]  s_data6 = '0;
  logic [2:0]  s_sel6 = '0;
  logic        s_bcast6 = 1'b0;
  logic [5:0]  m_valid6;
  logic [5:0]  m_ready6 = '0;
  logic [7:0]  m_data6;
  logic        err_sel6;
  logic [15:0] drop_cnt6;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stream_demux_1xn #(.DATA_W(8), .NUM_CH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid8), .s_ready(s_ready8), .s_data(s_data8),
    .s_sel(s_sel8), .s_bcast(s_bcast8),
    .m_valid(m_valid8), .m_ready(m_ready8), .m_data(m_data8),
    .err_sel(err_sel8), .drop_cnt(drop_cnt8)
  );

  stream_demux_1xn #(.DATA_W(8), .NUM_CH(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid6), .s_ready(s_ready6), .s_data(s_data6),
    .s_sel(s_sel6), .s_bcast(s_bcast6),
    .m_valid(m_valid6), .m_ready(m_ready6), .m_data(m_data6),
    .err_sel(err_sel6), .drop_cnt(drop_cnt6)
  );

  // Inputs change at posedge+1; outputs are checked at the following negedge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (s_ready8 !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready got %b exp 1", s_ready8); end
    n_checks++;
    if (m_valid8 !== 8'h00) begin n_fail++; $display("FAIL reset_m_valid got %h exp 00", m_valid8); end
    n_checks++;
    if (m_data8 !== 8'h00) begin n_fail++; $display("FAIL reset_m_data got %h exp 00", m_data8); end
    n_checks++;
    if (err_sel6 !== 1'b0 || drop_cnt6 !== 16'h0) begin
      n_fail++; $display("FAIL reset_err_drop got %b/%h exp 0/0000", err_sel6, drop_cnt6);
    end
    #21 rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_unicast();
    m_ready8 = 8'hFF; s_valid8 = 1'b1; s_data8 = 8'hA5; s_sel8 = 3'd3; s_bcast8 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (s_ready8 !== 1'b1 || m_valid8 !== 8'h00) begin
      n_fail++; $display("FAIL uni_accept got rdy=%b vld=%h exp 1/00", s_ready8, m_valid8);
    end
    next_cycle();
    s_valid8 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m_valid8 !== 8'h08 || m_data8 !== 8'hA5 || s_ready8 !== 1'b1) begin
      n_fail++; $display("FAIL uni_out got vld=%h data=%h rdy=%b exp 08/a5/1", m_valid8, m_data8, s_ready8);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (m_valid8 !== 8'h00) begin n_fail++; $display("FAIL uni_gone got %h exp 00", m_valid8); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_v;
    m_ready8 = 8'hFF; s_bcast8 = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      s_valid8 = (k < 16);
      s_sel8   = 3'(k % 8);
      s_data8  = 8'(8'h10 + k);
      @(negedge clk);
      n_checks++;
      if (s_ready8 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready k=%0d got %b exp 1", k, s_ready8); end
      exp_v = (k == 0) ? 8'h00 : 8'(1 << ((k - 1) % 8));
      n_checks++;
      if (m_valid8 !== exp_v) begin n_fail++; $display("FAIL b2b_valid k=%0d got %h exp %h", k, m_valid8, exp_v); end
      if (k > 0) begin
        n_checks++;
        if (m_data8 !== 8'(8'h10 + k - 1)) begin
          n_fail++; $display("FAIL b2b_data k=%0d got %h exp %h", k, m_data8, 8'(8'h10 + k - 1));
        end
      end
      next_cycle();
    end
    s_valid8 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m_valid8 !== 8'h00) begin n_fail++; $display("FAIL b2b_idle got %h exp 00", m_valid8); end
    next_cycle();
  endtask

  task automatic test_backpressure();
    m_ready8 = 8'hDF; s_bcast8 = 1'b0;
    s_valid8 = 1'b1; s_sel8 = 3'd5; s_data8 = 8'h3C;
    @(negedge clk);
    n_checks++;
    if (s_ready8 !== 1'b1) begin n_fail++; $display("FAIL bp_first_ready got %b exp 1", s_ready8); end
    next_cycle();
    s_sel8 = 3'd1; s_data8 = 8'h55;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (m_valid8 !== 8'h20 || m_data8 !== 8'h3C || s_ready8 !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_stall c=%0d got vld=%h data=%h rdy=%b exp 20/3c/0", c, m_valid8, m_data8, s_ready8);
      end
      next_cycle();
    end
    m_ready8 = 8'hFF;
    @(negedge clk);
    n_checks++;
    if (s_ready8 !== 1'b1 || m_valid8 !== 8'h20) begin
      n_fail++; $display("FAIL bp_release got rdy=%b vld=%h exp 1/20", s_ready8, m_valid8);
    end
    next_cycle();
    s_valid8 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m_valid8 !== 8'h02 || m_data8 !== 8'h55) begin
      n_fail++; $display("FAIL bp_follow got vld=%h data=%h exp 02/55", m_valid8, m_data8);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (m_valid8 !== 8'h00) begin n_fail++; $display("FAIL bp_idle got %h exp 00", m_valid8); end
    next_cycle();
  endtask

  task automatic test_broadcast();
    m_ready8 = 8'hFF; s_valid8 = 1'b1; s_bcast8 = 1'b1; s_sel8 = 3'd2; s_data8 = 8'h77;
    @(negedge clk);
    next_cycle();
    s_valid8 = 1'b0; s_bcast8 = 1'b0; m_ready8 = 8'h0F;
    @(negedge clk);
    n_checks++;
    if (m_valid8 !== 8'hFF || m_data8 !== 8'h77 || s_ready8 !== 1'b0) begin
      n_fail++; $display("FAIL bc_first got vld=%h data=%h rdy=%b exp ff/77/0", m_valid8, m_data8, s_ready8);
    end
    next_cycle();
    m_ready8 = 8'hF0;
    @(negedge clk);
    n_checks++;
    if (m_valid8 !== 8'hF0 || m_data8 !== 8'h77 || s_ready8 !== 1'b1) begin
      n_fail++; $display("FAIL bc_second got vld=%h data=%h rdy=%b exp f0/77/1", m_valid8, m_data8, s_ready8);
    end
    next_cycle();
    m_ready8 = 8'hFF;
    @(negedge clk);
    n_checks++;
    if (m_valid8 !== 8'h00) begin n_fail++; $display("FAIL bc_done got %h exp 00", m_valid8); end
    next_cycle();
  endtask

  task automatic test_out_of_range();
    m_ready6 = 6'h3F; s_bcast6 = 1'b0;
    s_valid6 = 1'b1; s_sel6 = 3'd7; s_data6 = 8'hEE;
    @(negedge clk);
    n_checks++;
    if (s_ready6 !== 1'b1) begin n_fail++; $display("FAIL oor_ready got %b exp 1", s_ready6); end
    next_cycle();
    s_sel6 = 3'd5; s_data6 = 8'h42;
    @(negedge clk);
    n_checks++;
    if (m_valid6 !== 6'h00 || err_sel6 !== 1'b1 || drop_cnt6 !== 16'd1) begin
      n_fail++; $display("FAIL oor_drop1 got vld=%h err=%b cnt=%h exp 00/1/0001", m_valid6, err_sel6, drop_cnt6);
    end
    next_cycle();
    s_sel6 = 3'd6;
    @(negedge clk);
    n_checks++;
    if (m_valid6 !== 6'h20 || m_data6 !== 8'h42 || err_sel6 !== 1'b0 || drop_cnt6 !== 16'd1) begin
      n_fail++;
      $display("FAIL oor_lastch got vld=%h data=%h err=%b cnt=%h exp 20/42/0/0001", m_valid6, m_data6, err_sel6, drop_cnt6);
    end
    next_cycle();
    s_valid6 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m_valid6 !== 6'h00 || err_sel6 !== 1'b1 || drop_cnt6 !== 16'd2) begin
      n_fail++; $display("FAIL oor_sel6 got vld=%h err=%b cnt=%h exp 00/1/0002", m_valid6, err_sel6, drop_cnt6);
    end
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (err_sel6 !== 1'b0) begin n_fail++; $display("FAIL oor_pulse got %b exp 0", err_sel6); end
    s_valid6 = 1'b1; s_sel6 = 3'd7;
    next_cycle();
    repeat (99) next_cycle();
    s_valid6 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (drop_cnt6 !== 16'd102) begin n_fail++; $display("FAIL oor_cnt102 got %0d exp 102", drop_cnt6); end
    next_cycle();
    s_valid6 = 1'b1;
    repeat (65500) next_cycle();
    s_valid6 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (drop_cnt6 !== 16'hFFFF || err_sel6 !== 1'b1 || m_valid6 !== 6'h00) begin
      n_fail++; $display("FAIL oor_sat got cnt=%h err=%b vld=%h exp ffff/1/00", drop_cnt6, err_sel6, m_valid6);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_op();
    m_ready8 = 8'h00; s_valid8 = 1'b1; s_bcast8 = 1'b1; s_data8 = 8'h99;
    next_cycle();
    s_valid8 = 1'b0; s_bcast8 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m_valid8 !== 8'hFF) begin n_fail++; $display("FAIL rst_pre got %h exp ff", m_valid8); end
    next_cycle();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (m_valid8 !== 8'h00 || m_data8 !== 8'h00 || s_ready8 !== 1'b1) begin
      n_fail++; $display("FAIL rst_async got vld=%h data=%h rdy=%b exp 00/00/1", m_valid8, m_data8, s_ready8);
    end
    n_checks++;
    if (drop_cnt6 !== 16'h0000) begin n_fail++; $display("FAIL rst_drop got %h exp 0000", drop_cnt6); end
    next_cycle();
    #2 rst_n = 1'b1;
    m_ready8 = 8'hFF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (m_valid8 !== 8'h00 || m_valid6 !== 6'h00 || err_sel6 !== 1'b0) begin
        n_fail++; $display("FAIL rst_after c=%0d got v8=%h v6=%h err=%b exp 00/00/0", c, m_valid8, m_valid6, err_sel6);
      end
      next_cycle();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_unicast();
    test_back_to_back();
    test_backpressure();
    test_broadcast();
    test_out_of_range();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
